fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencer for the fetch stage when instruction memory has variable latency. It owns the architectural PC and issues one-cycle read requests to instruction memory, then waits for each response. Each returned word is presented to decode through a one-entry output slot that downstream stalls can hold. It also applies branch/jump redirects from execute and the HALT stop from decode, discarding any in-flight response that was made stale.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, value of instr_o whenever valid_o=0.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  decode cannot accept; output slot must hold.
- redirect_i  in  1  one-cycle pulse from execute; branch/jump taken.
- redirect_pc_i  in  16  target PC, sampled with redirect_i.
- halt_i  in  1  one-cycle pulse from decode; HALT decoded.
- imem_req_o  out  1  one-cycle read request.
- imem_addr_o  out  16  read address, valid with imem_req_o.
- imem_done_i  in  1  one-cycle response strobe, at least 1 cycle after the request.
- imem_data_i  in  16  instruction word, valid with imem_done_i.
- valid_o  out  1  instr_o/pc_o hold a live instruction.
- instr_o  out  16  instruction to decode.
- pc_o  out  16  address of instr_o.
- pc_next_o  out  16  pc_o+2, used for link and branch base.
- halted_o  out  1  sticky; drives memory createdump.
- fetch_cnt_o  out  16  instructions delivered (see Configuration).
- wait_cyc_o  out  16  cycles spent in WAIT (see Configuration).

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN, HALT.
- **IDLE** (reset state): no request. Always goes to REQ on the next cycle.
- **REQ**: imem_req_o=1 and imem_addr_o=pc. Goes to WAIT. Any imem_done_i seen in this state is stale and is ignored.
- **WAIT**: on imem_done_i, the slot is free if valid_o=0 or stall_i=0.
  - If the slot is free: load the slot with {1, imem_data_i, pc}, set pc<=pc+2, and go to REQ.
  - Otherwise: capture the data into the hold register, set pc<=pc+2, and go to HOLD.
- **HOLD**: when stall_i=0, move the hold register into the slot and go to REQ.
- **Slot**: when valid_o=1 and stall_i=0 with no new load, valid_o drops to 0 (the instruction was consumed).
- **Redirect** has priority over done, stall and halt.
  - Effects: pc<=redirect_pc_i; the slot and hold register are invalidated (valid_o=0 next cycle).
  - From REQ or WAIT-without-done: go to DRAIN.
  - From WAIT-with-done, HOLD or IDLE: go to REQ (the response is discarded).
- **DRAIN**: no request. On imem_done_i, discard the data and go to HALT if halt_pend is set, else to REQ.
- **Halt** (when no redirect in the same cycle): set halt_pend and invalidate the slot and hold register.
  - From REQ or WAIT-without-done: go to DRAIN.
  - From other states: go to HALT.
- **HALT**: terminal until reset. halted_o=1, imem_req_o=0, valid_o=0. Redirect and halt are ignored.
- **Arithmetic**: PC math is 16-bit modulo; 16'hFFFE+2 = 16'h0000. pc_next_o = pc_o+2, with the same wrap.
- **Reset**: instruction memory is reset by the same rst_n, so no response survives reset.

## Timing
- Reset values: imem_req_o=0, imem_addr_o=RESET_PC, valid_o=0, instr_o=NOP_INSTR, pc_o=RESET_PC, pc_next_o=RESET_PC+2, halted_o=0, both counters 0, pc=RESET_PC, halt_pend=0.
- Reset assertion mid-operation forces these values immediately, without waiting for a clock edge.
- The first request is issued 1 cycle after rst_n deasserts.
- All outputs are registered except pc_next_o, which is combinational from pc_o.
- Timeline with 1-cycle memory latency:
  - req in cycle N, done in N+1;
  - valid_o=1 and the next req both in N+2.
- Peak throughput: 1 instruction per 2 cycles.
- A redirect in cycle N produces valid_o=0 in N+1. The first request to the target is issued:
  - at N+1 if nothing is outstanding;
  - otherwise 1 cycle after the stale done.
- halted_o rises the cycle after entering HALT.

## Configuration
- Macro `FETCH_PERF_EN`.
- Defined:
  - fetch_cnt_o increments by 1 on each slot load.
  - wait_cyc_o increments by 1 on each cycle spent in WAIT.
  - Both counters wrap at 16 bits and freeze in HALT.
- Undefined: the counters are not built; both ports are tied to 16'h0000.

## Test plan
- **Reset then straight-line fetch**: release rst_n, memory latency 1, words A,B at 0,2 -> req at 0 on cycle 1; valid_o with instr=A, pc_o=0000, pc_next_o=0002 on cycle 3; next req addr 0002.
- **Stall with response pending**: latency 3; stall_i held 5 cycles while valid_o=1 -> instr_o unchanged throughout; second word lands in HOLD; it appears the cycle after stall_i drops; no request is issued during HOLD.
- **Redirect with request outstanding**: redirect_i=1, target 0040, in the cycle after req 0006 -> valid_o=0 next cycle; data for 0006 discarded; next req addr 0040.
- **Halt with redirect in the same cycle**: redirect wins; no halt occurs. Halt alone during WAIT -> DRAIN, then HALT; halted_o=1; imem_req_o stays 0 for 20 cycles.
- **PC wrap**: RESET_PC=16'hFFFE -> first pc_o=FFFE, pc_next_o=0000, second req addr 0000.
- **Async reset mid-WAIT**: pull rst_n low between edges -> outputs at reset values immediately. With FETCH_PERF_EN, counters read 0 after reset and count 2 fetches, 2 wait cycles for two latency-1 fetches.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer for variable-latency instruction memory with a one-entry output slot.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  input  logic        halt_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_done_i,
  input  logic [15:0] imem_data_i,
  output logic        valid_o,
  output logic [15:0] instr_o,
  output logic [15:0] pc_o,
  output logic [15:0] pc_next_o,
  output logic        halted_o,
  output logic [15:0] fetch_cnt_o,
  output logic [15:0] wait_cyc_o
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_HALT} state_t;

  state_t      r_state, w_state_n;
  logic [15:0] r_pc, w_pc_n;
  logic        r_halt_pend, w_halt_pend_n;
  logic        r_valid, w_valid_n;
  logic [15:0] r_instr, w_instr_n, r_pc_o, w_pc_o_n;
  logic [15:0] r_hold_data, w_hold_data_n, r_hold_pc, w_hold_pc_n;
  logic        r_req, r_halted;
  logic [15:0] r_addr;
  logic        w_done_wait, w_slot_free, w_flush, w_busy;

  assign w_done_wait = (r_state == S_WAIT) && imem_done_i;
  assign w_slot_free = !r_valid || !stall_i;
  assign w_flush     = (r_state != S_HALT) && (redirect_i || halt_i);
  // a memory response is still owed after this cycle, so a flush must drain it
  assign w_busy      = (r_state == S_REQ) ||
                       ((r_state == S_WAIT || r_state == S_DRAIN) && !imem_done_i);

  always_comb begin
    w_state_n     = r_state;
    w_pc_n        = r_pc;
    w_halt_pend_n = r_halt_pend;
    w_valid_n     = r_valid;
    w_instr_n     = r_instr;
    w_pc_o_n      = r_pc_o;
    w_hold_data_n = r_hold_data;
    w_hold_pc_n   = r_hold_pc;
    if (r_valid && !stall_i) begin
      w_valid_n = 1'b0;
      w_instr_n = NOP_INSTR;
    end
    case (r_state)
      S_IDLE: w_state_n = S_REQ;
      S_REQ:  w_state_n = S_WAIT;
      S_WAIT: if (w_done_wait) begin
        w_pc_n = r_pc + 16'd2;
        if (w_slot_free) begin
          w_valid_n = 1'b1;
          w_instr_n = imem_data_i;
          w_pc_o_n  = r_pc;
          w_state_n = S_REQ;
        end else begin
          w_hold_data_n = imem_data_i;
          w_hold_pc_n   = r_pc;
          w_state_n     = S_HOLD;
        end
      end
      S_HOLD: if (!stall_i) begin
        w_valid_n = 1'b1;
        w_instr_n = r_hold_data;
        w_pc_o_n  = r_hold_pc;
        w_state_n = S_REQ;
      end
      S_DRAIN: if (imem_done_i) w_state_n = r_halt_pend ? S_HALT : S_REQ;
      default: ;
    endcase
    if (w_flush) begin
      w_valid_n = 1'b0;
      w_instr_n = NOP_INSTR;
      if (redirect_i) begin
        w_pc_n    = redirect_pc_i;
        w_state_n = w_busy ? S_DRAIN : S_REQ;
      end else begin
        w_halt_pend_n = 1'b1;
        w_state_n     = (w_busy && r_state != S_DRAIN) ? S_DRAIN : S_HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_halt_pend <= 1'b0;
      r_valid     <= 1'b0;
      r_instr     <= NOP_INSTR;
      r_pc_o      <= RESET_PC;
      r_hold_data <= NOP_INSTR;
      r_hold_pc   <= RESET_PC;
      r_req       <= 1'b0;
      r_addr      <= RESET_PC;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_pc        <= w_pc_n;
      r_halt_pend <= w_halt_pend_n;
      r_valid     <= w_valid_n;
      r_instr     <= w_instr_n;
      r_pc_o      <= w_pc_o_n;
      r_hold_data <= w_hold_data_n;
      r_hold_pc   <= w_hold_pc_n;
      r_req       <= (w_state_n == S_REQ);
      r_addr      <= w_pc_n;
      r_halted    <= (r_state == S_HALT);
    end
  end

  assign imem_req_o  = r_req;
  assign imem_addr_o = r_addr;
  assign valid_o     = r_valid;
  assign instr_o     = r_instr;
  assign pc_o        = r_pc_o;
  assign pc_next_o   = r_pc_o + 16'd2;
  assign halted_o    = r_halted;

`ifdef FETCH_PERF_EN
  logic [15:0] r_fetch_cnt, r_wait_cyc;
  logic        w_load;
  assign w_load = !w_flush && ((w_done_wait && w_slot_free) || (r_state == S_HOLD && !stall_i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= 16'h0000;
      r_wait_cyc  <= 16'h0000;
    end else if (r_state != S_HALT) begin
      if (w_load)            r_fetch_cnt <= r_fetch_cnt + 16'd1;
      if (r_state == S_WAIT) r_wait_cyc  <= r_wait_cyc + 16'd1;
    end
  end

  assign fetch_cnt_o = r_fetch_cnt;
  assign wait_cyc_o  = r_wait_cyc;
`else
  assign fetch_cnt_o = 16'h0000;
  assign wait_cyc_o  = 16'h0000;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a transaction-level scoreboard checked every negedge.
module tb_fetch_ctrl;
  localparam logic [15:0] NOP = 16'h0800;
`ifdef FETCH_PERF_EN
  localparam logic [15:0] EXP_CNT = 16'd2;
`else
  localparam logic [15:0] EXP_CNT = 16'd0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        stall_i = 1'b0, redirect_i = 1'b0, halt_i = 1'b0, imem_done_i = 1'b0;
  logic [15:0] redirect_pc_i = 16'h0, imem_data_i = 16'h0;
  logic        imem_req_o, valid_o, halted_o;
  logic [15:0] imem_addr_o, instr_o, pc_o, pc_next_o, fetch_cnt_o, wait_cyc_o;

  logic        w_done = 1'b0, w_req, w_valid, w_halted, w_pend = 1'b0;
  logic [15:0] w_data = 16'h0, w_addr, w_instr, w_pc, w_pc_next, w_fc, w_wc, w_paddr = 16'h0;

  int total = 0, bad = 0, cyc = 0, lat = 1;

  fetch_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .halt_i(halt_i), .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o), .imem_done_i(imem_done_i), .imem_data_i(imem_data_i),
    .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o), .pc_next_o(pc_next_o),
    .halted_o(halted_o), .fetch_cnt_o(fetch_cnt_o), .wait_cyc_o(wait_cyc_o));

  fetch_ctrl #(.RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall_i(1'b0), .redirect_i(1'b0),
    .redirect_pc_i(16'h0000), .halt_i(1'b0), .imem_req_o(w_req),
    .imem_addr_o(w_addr), .imem_done_i(w_done), .imem_data_i(w_data),
    .valid_o(w_valid), .instr_o(w_instr), .pc_o(w_pc), .pc_next_o(w_pc_next),
    .halted_o(w_halted), .fetch_cnt_o(w_fc), .wait_cyc_o(w_wc));

  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [15:0] a);
    return a ^ 16'h1234;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // memory models: requests seen at negedge, answered lat cycles later at posedge+2
  typedef struct { logic [15:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  initial forever begin @(posedge clk); cyc++; end
  initial forever begin
    @(negedge clk);
    if (!rst_n) mq.delete();
    else if (imem_req_o) mq.push_back('{imem_addr_o, cyc + lat});
    w_pend  = rst_n && w_req;
    w_paddr = w_addr;
  end
  initial forever begin
    @(posedge clk); #2;
    imem_done_i = 1'b0;
    imem_data_i = 16'h0;
    w_done = w_pend;
    w_data = mem(w_paddr);
    if (!rst_n) mq.delete();
    else if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_done_i = 1'b1;
      imem_data_i = mem(mq[0].addr);
      void'(mq.pop_front());
    end
  end

  // scoreboard: requested addresses still owed to decode, in order
  logic [15:0] sq[$];
  logic [15:0] exp_req = 16'h0000, p_instr = NOP, p_pc = 16'h0;
  bit exp_inv = 0, m_halt = 0, p_valid = 0, p_stall = 0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sq.delete();
      exp_req = 16'h0000; exp_inv = 0; m_halt = 0; p_valid = 0; p_stall = 0;
      chk("rst_valid", {15'd0, valid_o}, 16'd0);
      chk("rst_req", {15'd0, imem_req_o}, 16'd0);
    end else begin
      chk("pc_next", pc_next_o, pc_o + 16'd2);
      if (!valid_o) chk("nop_when_idle", instr_o, NOP);
      if (exp_inv) chk("flush_valid", {15'd0, valid_o}, 16'd0);
      if (m_halt) begin
        chk("halt_no_req", {15'd0, imem_req_o}, 16'd0);
        chk("halt_no_valid", {15'd0, valid_o}, 16'd0);
      end
      if (halted_o) chk("halted_implies_halt", {15'd0, m_halt}, 16'd1);
      if (valid_o) begin
        if (p_valid && p_stall) begin
          chk("stall_instr", instr_o, p_instr);
          chk("stall_pc", pc_o, p_pc);
        end else begin
          chk("deliver_pending", {15'd0, sq.size() != 0}, 16'd1);
          if (sq.size() != 0) begin
            chk("deliver_pc", pc_o, sq[0]);
            void'(sq.pop_front());
          end
          chk("deliver_instr", instr_o, mem(pc_o));
        end
      end
      if (imem_req_o) begin
        chk("req_addr", imem_addr_o, exp_req);
        sq.push_back(imem_addr_o);
        exp_req = imem_addr_o + 16'd2;
      end
      exp_inv = 0;
      if (!m_halt && redirect_i) begin
        sq.delete(); exp_req = redirect_pc_i; exp_inv = 1;
      end else if (!m_halt && halt_i) begin
        sq.delete(); m_halt = 1; exp_inv = 1;
      end
      p_valid = valid_o; p_stall = stall_i; p_instr = instr_o; p_pc = pc_o;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; halt_i = 1'b0;
    step(2);
    chk("r_req", {15'd0, imem_req_o}, 16'd0);
    chk("r_addr", imem_addr_o, 16'h0000);
    chk("r_valid", {15'd0, valid_o}, 16'd0);
    chk("r_instr", instr_o, NOP);
    chk("r_pc", pc_o, 16'h0000);
    chk("r_pcn", pc_next_o, 16'h0002);
    chk("r_halted", {15'd0, halted_o}, 16'd0);
    chk("r_fcnt", fetch_cnt_o, 16'h0000);
    chk("r_wcyc", wait_cyc_o, 16'h0000);
    rst_n = 1'b1;
  endtask

  initial begin
    // straight-line fetch, latency 1, with the FFFE-reset instance alongside
    lat = 1;
    do_reset();
    chk("w_rst_pcn", w_pc_next, 16'h0000);
    step(1);
    chk("t1_req", {15'd0, imem_req_o}, 16'd1);
    chk("t1_addr0", imem_addr_o, 16'h0000);
    chk("w_addr0", w_addr, 16'hFFFE);
    step(2);
    chk("t1_valid", {15'd0, valid_o}, 16'd1);
    chk("t1_instr", instr_o, 16'h1234);
    chk("t1_pc", pc_o, 16'h0000);
    chk("t1_pcn", pc_next_o, 16'h0002);
    chk("t1_addr2", imem_addr_o, 16'h0002);
    chk("w_pc", w_pc, 16'hFFFE);
    chk("w_pcn", w_pc_next, 16'h0000);
    chk("w_addr1", w_addr, 16'h0000);
    step(4);

    // stall with a response pending, latency 3
    lat = 3;
    do_reset();
    step(5);
    chk("t2_valid", {15'd0, valid_o}, 16'd1);
    chk("t2_instr", instr_o, 16'h1234);
    stall_i = 1'b1;
    for (int i = 6; i <= 9; i++) begin
      step(1);
      chk("t2_hold_instr", instr_o, 16'h1234);
    end
    chk("t2_hold_noreq", {15'd0, imem_req_o}, 16'd0);
    step(1);
    stall_i = 1'b0;
    chk("t2_c10_instr", instr_o, 16'h1234);
    chk("t2_c10_noreq", {15'd0, imem_req_o}, 16'd0);
    step(1);
    chk("t2_instr2", instr_o, 16'h1236);
    chk("t2_pc2", pc_o, 16'h0002);
    chk("t2_addr4", imem_addr_o, 16'h0004);
    step(2);

    // redirect with a request outstanding, latency 2
    lat = 2;
    do_reset();
    step(11);
    redirect_i = 1'b1; redirect_pc_i = 16'h0040;
    step(1);
    redirect_i = 1'b0;
    chk("t3_valid0", {15'd0, valid_o}, 16'd0);
    chk("t3_noreq", {15'd0, imem_req_o}, 16'd0);
    step(1);
    chk("t3_req", {15'd0, imem_req_o}, 16'd1);
    chk("t3_addr", imem_addr_o, 16'h0040);
    step(3);
    chk("t3_instr", instr_o, 16'h1274);
    chk("t3_pc", pc_o, 16'h0040);

    // halt and redirect together: redirect wins
    step(1);
    halt_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 16'h0080;
    step(1);
    halt_i = 1'b0; redirect_i = 1'b0;
    chk("t4_halted0", {15'd0, halted_o}, 16'd0);
    step(1);
    chk("t4_addr", imem_addr_o, 16'h0080);
    step(1);
    halt_i = 1'b1;
    step(1);
    halt_i = 1'b0;
    chk("t4_valid0", {15'd0, valid_o}, 16'd0);
    step(1);
    chk("t4_not_yet", {15'd0, halted_o}, 16'd0);
    step(1);
    chk("t4_halted", {15'd0, halted_o}, 16'd1);
    redirect_i = 1'b1; redirect_pc_i = 16'h0100;
    for (int i = 0; i < 20; i++) begin
      step(1);
      redirect_i = 1'b0;
      chk("t4_stay_noreq", {15'd0, imem_req_o}, 16'd0);
      chk("t4_stay_halted", {15'd0, halted_o}, 16'd1);
    end

    // asynchronous reset mid-WAIT, then counter check
    lat = 1;
    do_reset();
    step(4);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_req", {15'd0, imem_req_o}, 16'd0);
    chk("t6_addr", imem_addr_o, 16'h0000);
    chk("t6_valid", {15'd0, valid_o}, 16'd0);
    chk("t6_instr", instr_o, NOP);
    chk("t6_pcn", pc_next_o, 16'h0002);
    chk("t6_fcnt", fetch_cnt_o, 16'h0000);
    chk("t6_wcyc", wait_cyc_o, 16'h0000);
    step(2);
    rst_n = 1'b1;
    step(5);
    chk("t6_instr2", instr_o, 16'h1236);
    chk("t6_fcnt2", fetch_cnt_o, EXP_CNT);
    chk("t6_wcyc2", wait_cyc_o, EXP_CNT);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
